cacc_ram_fifo_ctrl: RTL



---
 rtl/cacc_ram_fifo_ctrl_if.sv | 29 ++
 rtl/cacc_ram_fifo_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/cacc_ram_fifo_ctrl_if.sv
// Bus bundle for cacc_ram_fifo_ctrl: write stream, read stream and the
// 1R1W RAM macro port. master = controller side, slave = environment side.
interface cacc_ram_fifo_ctrl_if #(
    parameter int unsigned DW = 512,
    parameter int unsigned AW = 5
);
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;

    modport master (
        input  wr_pvld, wr_pd, rd_prdy, ram_dout,
        output wr_prdy, rd_pvld, rd_pd, ram_re, ram_ra, ram_we, ram_wa, ram_di
    );

    modport slave (
        output wr_pvld, wr_pd, rd_prdy, ram_dout,
        input  wr_prdy, rd_pvld, rd_pd, ram_re, ram_ra, ram_we, ram_wa, ram_di
    );
endinterface

// File: rtl/cacc_ram_fifo_ctrl.sv
// FIFO controller in front of a 1R1W registered-read RAM macro.
// A 2-entry output buffer hides the RAM read latency so the FIFO sustains
// one entry per cycle; total capacity is DEPTH+2.
// Optional build macro CACC_RAMCTL_STATUS_EN adds fifo_occ / fifo_hwm.
module cacc_ram_fifo_ctrl #(
    parameter int unsigned DW    = 512,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 32
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    cacc_ram_fifo_ctrl_if.master     bus
`ifdef CACC_RAMCTL_STATUS_EN
    ,
    output logic [AW+1:0]            fifo_occ,
    output logic [AW+1:0]            fifo_hwm
`endif
);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] ram_cnt;
    logic          rd_inflight;
    logic [1:0]    ob_cnt;
    logic [DW-1:0] ob0;
    logic [DW-1:0] ob1;

    logic          ram_full_c;
    logic          ram_we_c;
    logic          ram_re_c;
    logic          pop_c;
    logic          cap_c;
    logic [2:0]    vis_after_pop_c;
    logic [CW-1:0] ram_cnt_nxt_c;

    // Handshake decode, read-issue decision and next RAM count.
    // The visible head is ob0 when the buffer holds data, otherwise the RAM
    // word returning this cycle, so an entry written into an empty FIFO is
    // presented two cycles after acceptance.
    always_comb begin
        ram_full_c      = (ram_cnt == CW'(DEPTH));
        ram_we_c        = bus.wr_pvld & ~ram_full_c;
        pop_c           = bus.rd_pvld & bus.rd_prdy;
        vis_after_pop_c = 3'(ob_cnt) + 3'(rd_inflight) - 3'(pop_c);
        ram_re_c        = (ram_cnt != '0) && (vis_after_pop_c < 3'd2);
        cap_c           = rd_inflight & ~((ob_cnt == 2'd0) & pop_c);
        ram_cnt_nxt_c   = ram_cnt + CW'(ram_we_c) - CW'(ram_re_c);
    end

    assign bus.wr_prdy = ~ram_full_c;
    assign bus.ram_we  = ram_we_c;
    assign bus.ram_wa  = wr_ptr;
    assign bus.ram_di  = bus.wr_pd;
    assign bus.ram_re  = ram_re_c;
    assign bus.ram_ra  = rd_ptr;
    assign bus.rd_pvld = (ob_cnt != 2'd0) | rd_inflight;
    assign bus.rd_pd   = (ob_cnt != 2'd0) ? ob0 : bus.ram_dout;

    // Pointer, count and buffer-occupancy state.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            ob_cnt      <= 2'd0;
        end else begin
            if (ram_we_c) wr_ptr <= wr_ptr + AW'(1);
            if (ram_re_c) rd_ptr <= rd_ptr + AW'(1);
            ram_cnt     <= ram_cnt_nxt_c;
            rd_inflight <= ram_re_c;
            ob_cnt      <= vis_after_pop_c[1:0];
        end
    end

    // Output buffer payload: shift on pop, capture returning RAM data into
    // the first free slot unless it was consumed directly.
    always_ff @(posedge nvdla_core_clk) begin
        if (pop_c && (ob_cnt == 2'd2)) ob0 <= ob1;
        if (cap_c) begin
            if ((ob_cnt == 2'd1) && !pop_c) ob1 <= bus.ram_dout;
            else                            ob0 <= bus.ram_dout;
        end
    end

`ifdef CACC_RAMCTL_STATUS_EN
    localparam int unsigned OW = AW + 2;
    logic [OW-1:0] occ_nxt_c;

    // Next total occupancy: RAM + in-flight read + output buffer.
    always_comb begin
        occ_nxt_c = OW'(ram_cnt_nxt_c) + OW'(ram_re_c) + OW'(vis_after_pop_c[1:0]);
    end

    // Registered occupancy and its sticky high-water mark.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            fifo_occ <= '0;
            fifo_hwm <= '0;
        end else begin
            fifo_occ <= occ_nxt_c;
            if (occ_nxt_c > fifo_hwm) fifo_hwm <= occ_nxt_c;
        end
    end
`endif
endmodule
